multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style controller FSM that sequences a shared-memory multicycle RV32I datapath (PC, IR, register file, single ALU, unified instruction/data memory).
- Replaces the single-cycle control unit in the multicycle core variant.
- Drives per-state mux selects and write strobes, waits on a memory ready handshake, and counts retired instructions.
- Supported opcodes: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed current access this cycle.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  IR/OldPC enable.
- resultsrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alusrca  out  2  SrcA: 00 = PC, 01 = OldPC, 10 = rs1 data.
- alusrcb  out  2  SrcB: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- immsrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- regwrite  out  1  register file write enable.
- alucontrol  out  3  ALU operation.
- mem_req  out  1  memory access in progress (FETCH, MEMREAD, MEMWRITE).
- instret  out  CNT_W  retired instruction count.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL. Encoding is binary, 4 bits.
- Reset: asynchronous to FETCH; instret = 0. While reset_n = 0, pcwrite, irwrite, regwrite and memwrite are forced 0.
- pcwrite = pcupdate | (branch & zero). pcupdate and branch are internal state decodes.
- FETCH:
  - Outputs: adrsrc = 0, alusrca = 00, alusrcb = 10, aluop = 00, resultsrc = 10, mem_req = 1.
  - irwrite = pcupdate = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE:
  - Outputs: alusrca = 01, alusrcb = 01, aluop = 00 (branch target into ALUOut).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other -> see Optional Feature.
- MEMADR:
  - Outputs: alusrca = 10, alusrcb = 01, aluop = 00.
  - Next state: lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD:
  - Outputs: adrsrc = 1, resultsrc = 00, mem_req = 1.
  - Holds until mem_ready = 1, then goes to MEMWB.
- MEMWB: resultsrc = 01, regwrite = 1, then FETCH.
- MEMWRITE:
  - Outputs: adrsrc = 1, resultsrc = 00, mem_req = 1; memwrite = 1 held steady while waiting.
  - On mem_ready = 1, goes to FETCH.
- EXECUTER: alusrca = 10, alusrcb = 00, aluop = 10, then ALUWB.
- EXECUTEI: alusrca = 10, alusrcb = 01, aluop = 10, then ALUWB.
- ALUWB: resultsrc = 00, regwrite = 1, then FETCH.
- BEQ:
  - Outputs: alusrca = 10, alusrcb = 00, aluop = 01, resultsrc = 00, branch = 1.
  - Next state: FETCH.
- JAL:
  - Outputs: alusrca = 01, alusrcb = 10, aluop = 00, resultsrc = 00, pcupdate = 1.
  - Next state: ALUWB.
- Outputs not listed for a state are 0. Select fields not listed are 00.
- immsrc is combinational from op in all states: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- alucontrol comes from the ALU decoder with inputs aluop, funct3, funct7b5, op[5]:
  - aluop 00 -> add (000); aluop 01 -> sub (001).
  - aluop 10: funct3 000 -> sub (001) if op[5] & funct7b5, else add (000); 010 -> slt (101); 110 -> or (011); 111 -> and (010).
- instret:
  - Increments by 1 on a clock edge leaving MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready = 1.
  - Wraps modulo 2^CNT_W.
- Reset mid-instruction aborts immediately: no strobe glitch, counter cleared.
- mem_ready outside memory states is ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> state TRAP, which asserts output illegal_instr = 1 and all strobes 0.
  - TRAP is held until reset.
  - illegal_instr port exists only when the macro is defined.
- Undefined: unknown opcode in DECODE -> FETCH (executes as NOP, not counted in instret).

Decomposition:
- Shared package rv_ctrl_pkg:
  - State enum.
  - Opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL.
  - ALUOP_ADD/SUB/FUNCT.
  - alucontrol codes.
  - resultsrc/alusrca/alusrcb/immsrc encodings.
- One sub-module: the existing alu_decoder, reused unchanged. The FSM body stays flat.

Test Plan:
- lw x5,4(x0) (IR 0x00402283), mem_ready = 1 always -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite = 1 with resultsrc = 01 in cycle 5; instret 0 -> 1.
- add x6,x5,x10 (0x00A28333) -> EXECUTER with alucontrol = 000, then ALUWB with regwrite = 1; sub (0x40A28333) gives alucontrol = 001.
- sw with mem_ready held low 3 cycles -> MEMWRITE held 4 cycles with memwrite = 1 steady; FETCH on cycle after mem_ready; instret +1 once.
- beq: zero = 1 -> pcwrite = 1 in BEQ; zero = 0 -> pcwrite = 0; both retire.
- reset_n pulsed low during MEMREAD -> asynchronous return to FETCH; instret = 0; no regwrite issued.
- Opcode 0x7F: macro off -> DECODE then FETCH, instret unchanged; macro on -> TRAP with illegal_instr = 1 held.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU op classes and the datapath mux select codes.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_type(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath (slave): instruction fields and flags in, selects and strobes out.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             mem_ready;

    logic             pcwrite;
    logic             adrsrc;
    logic             memwrite;
    logic             irwrite;
    logic [1:0]       resultsrc;
    logic [1:0]       alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       immsrc;
    logic             regwrite;
    logic [2:0]       alucontrol;
    logic             mem_req;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               immsrc, regwrite, alucontrol, mem_req, instret
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               immsrc, regwrite, alucontrol, mem_req, instret
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALU op class plus funct3/funct7b5/op[5]
// onto the ALU operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // op[5] separates R-type sub from I-type addi with imm[10] set
                    3'b000:  o_alucontrol = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alucontrol = ALU_SLT;
                    3'b110:  o_alucontrol = ALU_OR;
                    3'b111:  o_alucontrol = ALU_AND;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller sequencing a shared-memory multicycle RV32I datapath.
// Define MULTICYCLE_CTRL_TRAP_EN to trap unknown opcodes (adds illegal_instr).
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic reset_n,
`ifdef MULTICYCLE_CTRL_TRAP_EN
    output logic illegal_instr,
`endif
    multicycle_ctrl_if.master ctrl_bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instret;

    logic       w_pcupdate;
    logic       w_branch;
    logic       w_adrsrc;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_mem_req;
    logic       w_retire;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [2:0] w_alucontrol;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic       w_illegal;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pcupdate   = 1'b0;
        w_branch     = 1'b0;
        w_adrsrc     = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_mem_req    = 1'b0;
        w_retire     = 1'b0;
        w_resultsrc  = RES_ALUOUT;
        w_alusrca    = SRCA_PC;
        w_alusrcb    = SRCB_RS2;
        w_aluop      = ALUOP_ADD;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        w_illegal    = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_alusrcb   = SRCB_FOUR;
                w_resultsrc = RES_ALURESULT;
                w_mem_req   = 1'b1;
                w_irwrite   = ctrl_bus.mem_ready;
                w_pcupdate  = ctrl_bus.mem_ready;
                if (ctrl_bus.mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                case (ctrl_bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    default:      w_next_state = S_TRAP;
`else
                    default:      w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_next_state = (ctrl_bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc  = 1'b1;
                w_mem_req = 1'b1;
                if (ctrl_bus.mem_ready) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc  = RES_DATA;
                w_regwrite   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = ctrl_bus.mem_ready;
                if (ctrl_bus.mem_ready) w_next_state = S_FETCH;
            end
            S_EXECUTER: begin
                w_alusrca    = SRCA_RS1;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca    = SRCA_RS1;
                w_aluop      = ALUOP_SUB;
                w_branch     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC+4 (OldPC+4) goes to rd via ALUWB while ALUOut redirects PC
                w_alusrca    = SRCA_OLDPC;
                w_alusrcb    = SRCB_FOUR;
                w_pcupdate   = 1'b1;
                w_next_state = S_ALUWB;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: begin
                w_illegal    = 1'b1;
                w_next_state = S_TRAP;
            end
`endif
            default: w_next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct3     (ctrl_bus.funct3),
        .i_funct7b5   (ctrl_bus.funct7b5),
        .i_op5        (ctrl_bus.op[5]),
        .o_alucontrol (w_alucontrol)
    );

    // strobes are gated by reset_n so an aborting reset never glitches a write
    assign ctrl_bus.pcwrite    = reset_n & (w_pcupdate | (w_branch & ctrl_bus.zero));
    assign ctrl_bus.irwrite    = reset_n & w_irwrite;
    assign ctrl_bus.regwrite   = reset_n & w_regwrite;
    assign ctrl_bus.memwrite   = reset_n & w_memwrite;
    assign ctrl_bus.adrsrc     = w_adrsrc;
    assign ctrl_bus.resultsrc  = w_resultsrc;
    assign ctrl_bus.alusrca    = w_alusrca;
    assign ctrl_bus.alusrcb    = w_alusrcb;
    assign ctrl_bus.immsrc     = imm_type(ctrl_bus.op);
    assign ctrl_bus.alucontrol = w_alucontrol;
    assign ctrl_bus.mem_req    = w_mem_req;
    assign ctrl_bus.instret    = r_instret;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign illegal_instr       = w_illegal;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction micro-step model,
// one per-cycle compare process, plus literal pins (honours MULTICYCLE_CTRL_TRAP_EN).
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;   // small counter so the wrap is exercised

    typedef struct packed {
        logic             pcwrite;
        logic             adrsrc;
        logic             memwrite;
        logic             irwrite;
        logic [1:0]       resultsrc;
        logic [1:0]       alusrca;
        logic [1:0]       alusrcb;
        logic [1:0]       immsrc;
        logic             regwrite;
        logic [2:0]       alucontrol;
        logic             mem_req;
        logic             illegal;
        logic [CNT_W-1:0] instret;
    } ctl_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus_if ();
`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic illegal_instr;
`endif

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef MULTICYCLE_CTRL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .ctrl_bus      (bus_if.master)
    );

    int               n_total   = 0;
    int               n_bad     = 0;
    ctl_t             exp_c     = '0;
    logic             exp_valid = 1'b0;
    string            exp_tag   = "";
    logic [CNT_W-1:0] m_instret = '0;
    logic [31:0]      cur_ir    = 32'h0;
    logic             cur_zero  = 1'b0;
    ctl_t             snap[$];

    function automatic ctl_t dut_ctl();
        ctl_t c;
        c.pcwrite    = bus_if.pcwrite;
        c.adrsrc     = bus_if.adrsrc;
        c.memwrite   = bus_if.memwrite;
        c.irwrite    = bus_if.irwrite;
        c.resultsrc  = bus_if.resultsrc;
        c.alusrca    = bus_if.alusrca;
        c.alusrcb    = bus_if.alusrcb;
        c.immsrc     = bus_if.immsrc;
        c.regwrite   = bus_if.regwrite;
        c.alucontrol = bus_if.alucontrol;
        c.mem_req    = bus_if.mem_req;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        c.illegal    = illegal_instr;
`else
        c.illegal    = 1'b0;
`endif
        c.instret    = bus_if.instret;
        return c;
    endfunction

    // immediate format implied by the instruction class
    function automatic logic [1:0] imm_for(input logic [6:0] op);
        case (op)
            7'h23:   return 2'b01;
            7'h63:   return 2'b10;
            7'h6F:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // ALU operation the instruction's semantics require in its execute step
    function automatic logic [2:0] alu_for(input logic [31:0] ir);
        case (ir[14:12])
            3'b000:  return (ir[6:0] == 7'h33 && ir[30]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t quiet(input logic [31:0] ir);
        ctl_t c = '0;
        c.immsrc = imm_for(ir[6:0]);
        return c;
    endfunction

    always @(negedge clk) begin
        ctl_t got;
        if (exp_valid) begin
            got = dut_ctl();
            n_total++;
            if (got !== exp_c) begin
                n_bad++;
                $display("FAIL cycle-%s t=%0t ir=%08h: got=%h want=%h", exp_tag, $time, cur_ir, got, exp_c);
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step(input string tag, input ctl_t c, input logic mr, input logic retire);
        @(posedge clk);
        #1;
        bus_if.op        = cur_ir[6:0];
        bus_if.funct3    = cur_ir[14:12];
        bus_if.funct7b5  = cur_ir[30];
        bus_if.zero      = cur_zero;
        bus_if.mem_ready = mr;
        exp_c            = c;
        exp_c.instret    = m_instret;
        exp_tag          = tag;
        exp_valid        = 1'b1;
        @(negedge clk);
        snap.push_back(dut_ctl());
        if (retire) m_instret = m_instret + CNT_W'(1);
    endtask

    task automatic aluwb(input logic [31:0] ir);
        ctl_t c;
        c          = quiet(ir);
        c.regwrite = 1'b1;
        step("aluwb", c, 1'b1, 1'b1);
    endtask

    task automatic run_instr(input string name, input logic [31:0] ir, input logic z,
                             input int fwait, input int mwait, input bit abort);
        ctl_t c;
        cur_ir   = ir;
        cur_zero = z;
        snap.delete();
        for (int i = 0; i <= fwait; i++) begin
            c           = quiet(ir);
            c.alusrcb   = 2'b10;
            c.resultsrc = 2'b10;
            c.mem_req   = 1'b1;
            c.pcwrite   = (i == fwait);
            c.irwrite   = (i == fwait);
            step("fetch", c, (i == fwait), 1'b0);
        end
        c         = quiet(ir);
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        step("decode", c, 1'b1, 1'b0);
        case (ir[6:0])
            7'h03, 7'h23: begin
                c         = quiet(ir);
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                step("memadr", c, 1'b1, 1'b0);
                for (int i = 0; i <= mwait; i++) begin
                    if (abort && i == mwait) return;
                    c          = quiet(ir);
                    c.adrsrc   = 1'b1;
                    c.mem_req  = 1'b1;
                    c.memwrite = (ir[6:0] == 7'h23);
                    step("memaccess", c, (i == mwait), c.memwrite && (i == mwait));
                end
                if (ir[6:0] == 7'h03) begin
                    c           = quiet(ir);
                    c.resultsrc = 2'b01;
                    c.regwrite  = 1'b1;
                    step("memwb", c, 1'b1, 1'b1);
                end
            end
            7'h33, 7'h13: begin
                c            = quiet(ir);
                c.alusrca    = 2'b10;
                c.alusrcb    = (ir[6:0] == 7'h13) ? 2'b01 : 2'b00;
                c.alucontrol = alu_for(ir);
                step("execute", c, 1'b1, 1'b0);
                aluwb(ir);
            end
            7'h63: begin
                c            = quiet(ir);
                c.alusrca    = 2'b10;
                c.alucontrol = 3'b001;
                c.pcwrite    = z;
                step("beq", c, 1'b1, 1'b1);
            end
            7'h6F: begin
                c         = quiet(ir);
                c.alusrca = 2'b01;
                c.alusrcb = 2'b10;
                c.pcwrite = 1'b1;
                step("jal", c, 1'b1, 1'b0);
                aluwb(ir);
            end
            default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                for (int i = 0; i < 3; i++) begin
                    c         = quiet(ir);
                    c.illegal = 1'b1;
                    step("trap", c, 1'b1, 1'b0);
                end
`endif
            end
        endcase
        $display("instr %-8s ir=%08h zero=%0b cycles=%0d retired=%0d", name, ir, z, snap.size(), m_instret);
    endtask

    task automatic apply_reset(input string why);
        exp_valid = 1'b0;
        #1;
        bus_if.mem_ready = 1'b1;
        reset_n          = 1'b0;
        #1;
        pin({why, "-async-pcwrite"},  32'(bus_if.pcwrite),  32'd0);
        pin({why, "-async-irwrite"},  32'(bus_if.irwrite),  32'd0);
        pin({why, "-async-regwrite"}, 32'(bus_if.regwrite), 32'd0);
        pin({why, "-async-memwrite"}, 32'(bus_if.memwrite), 32'd0);
        pin({why, "-async-instret"},  32'(bus_if.instret),  32'd0);
        pin({why, "-async-fetch"},    32'(bus_if.mem_req),  32'd1);
        @(posedge clk);
        #1;
        pin({why, "-held-irwrite"},   32'(bus_if.irwrite),  32'd0);
        pin({why, "-held-pcwrite"},   32'(bus_if.pcwrite),  32'd0);
        bus_if.mem_ready = 1'b0;
        reset_n          = 1'b1;
        m_instret        = '0;
        $display("reset %s", why);
    endtask

    initial begin
        int nmw;
        bus_if.op        = 7'h0;
        bus_if.funct3    = 3'h0;
        bus_if.funct7b5  = 1'b0;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b0;

        apply_reset("power-on");

        run_instr("lw", 32'h00402283, 1'b0, 0, 0, 1'b0);
        pin("lw-wb-regwrite",  32'(snap[4].regwrite),  32'd1);
        pin("lw-wb-resultsrc", 32'(snap[4].resultsrc), 32'd1);

        run_instr("add", 32'h00A28333, 1'b0, 0, 0, 1'b0);
        pin("add-instret-after-lw", 32'(snap[0].instret), 32'd1);
        pin("add-alucontrol",       32'(snap[2].alucontrol), 32'd0);
        pin("add-regwrite",         32'(snap[3].regwrite), 32'd1);

        run_instr("sub", 32'h40A28333, 1'b0, 0, 0, 1'b0);
        pin("sub-alucontrol", 32'(snap[2].alucontrol), 32'd1);

        run_instr("sw", 32'h00502423, 1'b0, 1, 3, 1'b0);
        nmw = 0;
        foreach (snap[i]) nmw += int'(snap[i].memwrite);
        pin("sw-memwrite-cycles", 32'(nmw), 32'd4);

        run_instr("beq-t", 32'h00000463, 1'b1, 0, 0, 1'b0);
        pin("beq-taken-pcwrite", 32'(snap[2].pcwrite), 32'd1);
        run_instr("beq-nt", 32'h00000463, 1'b0, 0, 0, 1'b0);
        pin("beq-nt-instret", 32'(snap[0].instret), 32'd5);
        pin("beq-nt-pcwrite", 32'(snap[2].pcwrite), 32'd0);

        run_instr("addi", 32'h00500093, 1'b0, 0, 0, 1'b0);
        run_instr("slti", 32'h00312093, 1'b0, 2, 0, 1'b0);
        run_instr("or", 32'h0062E3B3, 1'b0, 0, 0, 1'b0);
        run_instr("and", 32'h0062F3B3, 1'b0, 0, 0, 1'b0);
        run_instr("addi-b30", 32'h40000093, 1'b0, 0, 0, 1'b0);
        pin("addi-b30-alucontrol", 32'(snap[2].alucontrol), 32'd0);
        run_instr("jal", 32'h010000EF, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 5; k++) run_instr("add", 32'h00A28333, 1'b1, 0, 0, 1'b0);

        run_instr("illegal", 32'h0000007F, 1'b0, 0, 0, 1'b0);
        pin("instret-wrapped", 32'(snap[0].instret), 32'd1);
`ifdef MULTICYCLE_CTRL_TRAP_EN
        pin("trap-held", 32'(snap[4].illegal), 32'd1);
        apply_reset("leave-trap");
`endif

        run_instr("lw-abort", 32'h00402283, 1'b0, 0, 2, 1'b1);
`ifdef MULTICYCLE_CTRL_TRAP_EN
        pin("illegal-not-counted", 32'(snap[0].instret), 32'd0);
`else
        pin("illegal-not-counted", 32'(snap[0].instret), 32'd1);
`endif
        apply_reset("mid-memread");

        run_instr("lw", 32'h00402283, 1'b0, 2, 1, 1'b0);
        pin("post-reset-instret", 32'(snap[0].instret), 32'd0);
        run_instr("jal", 32'h010000EF, 1'b0, 0, 0, 1'b0);
        pin("jal-instret", 32'(snap[0].instret), 32'd1);
        run_instr("add", 32'h00A28333, 1'b0, 0, 0, 1'b0);
        pin("final-instret", 32'(snap[0].instret), 32'd2);

        exp_valid = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
